alu_cmd_issuer: RTL and testbench

- Initiator side of the ALU operand interface. Drives OPCODE/OP1/OP2 into the ALU and collects its result after a fixed latency.
- Upstream commands are queued in a small FIFO and issued one at a time.
- Each result is returned upstream on a valid/ready response channel, tagged with its opcode.
- Sits between the command source (test sequencer or core) and the alu instance.

---
 rtl/alu_cmd_issuer.sv | 218 +++++++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: initiator side of the ALU operand interface.
//
// Queues upstream commands in a small FIFO, issues them one at a time onto the
// ALU inputs, waits a fixed ALU latency, captures the result and returns it on
// a valid/ready response channel tagged with its opcode.
//
// Parameters:
//   W        operand width
//   ALU_LAT  cycles from operands driven to alu_res valid (1..7)
//   DEPTH    command FIFO entries (power of two, >= 2)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           upstream command handshake
//   cmd_opcode/cmd_op1/cmd_op2    command payload
//   OPCODE/OP1/OP2                registered operands to the ALU
//   alu_res                       ALU result (bit W is carry/flag)
//   rsp_valid/rsp_ready           response handshake
//   rsp_data/rsp_opcode           captured result and its opcode
//   busy                          FSM not idle or FIFO non-empty
//
// Optional feature macro: ALU_ISSUER_STATS_EN
//   adds issue_cnt (wrapping count of issues) and stall_cnt (saturating count
//   of response cycles with rsp_ready low).
module alu_cmd_issuer #(
    parameter int unsigned W       = 4,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [2:0]     cmd_opcode,
    input  logic [W-1:0]   cmd_op1,
    input  logic [W-1:0]   cmd_op2,
    output logic [2:0]     OPCODE,
    output logic [W-1:0]   OP1,
    output logic [W-1:0]   OP2,
    input  logic [W:0]     alu_res,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W:0]     rsp_data,
    output logic [2:0]     rsp_opcode,
    output logic           busy
`ifdef ALU_ISSUER_STATS_EN
    ,
    output logic [15:0]    issue_cnt,
    output logic [15:0]    stall_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e state_q, state_d;

    // FIFO storage and bookkeeping
    logic [2:0]    fifo_opc [DEPTH];
    logic [W-1:0]  fifo_op1 [DEPTH];
    logic [W-1:0]  fifo_op2 [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    logic          push;
    logic          pop;
    logic          capture;
    logic          fifo_empty;
    logic [2:0]    wait_q;

    assign fifo_empty = (count_q == '0);
    // Ready comes from the registered count only, so a same-cycle pop never
    // reopens a full FIFO.
    assign cmd_ready  = (count_q != CW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign rsp_valid  = (state_q == StResp);
    assign busy       = (state_q != StIdle) || !fifo_empty;

    // Next-state logic; every pop coincides with a transition into StIssue.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (wait_q == 3'd0) begin
                    capture = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = StIssue;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO payload; no reset needed, occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_opc[wr_ptr_q] <= cmd_opcode;
            fifo_op1[wr_ptr_q] <= cmd_op1;
            fifo_op2[wr_ptr_q] <= cmd_op2;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Operand registers: only reloaded on a pop, so they stay put while a
    // result is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            OPCODE <= '0;
            OP1    <= '0;
            OP2    <= '0;
        end else if (pop) begin
            OPCODE <= fifo_opc[rd_ptr_q];
            OP1    <= fifo_op1[rd_ptr_q];
            OP2    <= fifo_op2[rd_ptr_q];
        end
    end

    // Latency counter: loaded in ISSUE, counts down through WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
        end else if (state_q == StIssue) begin
            wait_q <= 3'(ALU_LAT - 1);
        end else if (state_q == StWait && wait_q != 3'd0) begin
            wait_q <= wait_q - 3'd1;
        end
    end

    // Response capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data   <= '0;
            rsp_opcode <= '0;
        end else if (capture) begin
            rsp_data   <= alu_res;
            rsp_opcode <= OPCODE;
        end
    end

`ifdef ALU_ISSUER_STATS_EN
    logic [15:0] issue_cnt_q;
    logic [15:0] stall_cnt_q;

    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop) begin
                issue_cnt_q <= issue_cnt_q + 16'd1;
            end
            if (state_q == StResp && !rsp_ready && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: table-driven single-command vectors,
// a scoreboard on the response channel, and hand-written fill, back-to-back,
// reset and (when ALU_ISSUER_STATS_EN is defined) statistics sequences.
module tb_alu_cmd_issuer;

    localparam int unsigned W       = 4;
    localparam int unsigned ALU_LAT = 1;
    localparam int unsigned DEPTH   = 4;

    logic           clk;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [2:0]     cmd_opcode;
    logic [W-1:0]   cmd_op1;
    logic [W-1:0]   cmd_op2;
    logic [2:0]     OPCODE;
    logic [W-1:0]   OP1;
    logic [W-1:0]   OP2;
    logic [W:0]     alu_res;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W:0]     rsp_data;
    logic [2:0]     rsp_opcode;
    logic           busy;
`ifdef ALU_ISSUER_STATS_EN
    logic [15:0]    issue_cnt;
    logic [15:0]    stall_cnt;
`endif

    alu_cmd_issuer #(
        .W       (W),
        .ALU_LAT (ALU_LAT),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_op1    (cmd_op1),
        .cmd_op2    (cmd_op2),
        .OPCODE     (OPCODE),
        .OP1        (OP1),
        .OP2        (OP2),
        .alu_res    (alu_res),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_opcode (rsp_opcode),
        .busy       (busy)
`ifdef ALU_ISSUER_STATS_EN
        ,
        .issue_cnt  (issue_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference ALU: combinational, so it is valid well before the capture edge.
    function automatic logic [W:0] alu_fn(input logic [2:0] opc, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        case (opc)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    always_comb alu_res = alu_fn(OPCODE, OP1, OP2);

    // Scoreboard: push on command acceptance, pop on response handshake.
    typedef struct packed {
        logic [2:0] opc;
        logic [W:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    exp_t sb_n;

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_rsp_data", 32'(rsp_data), 32'(sb_e.data));
                    check("sb_rsp_opcode", 32'(rsp_opcode), 32'(sb_e.opc));
                end
            end
            if (cmd_valid && cmd_ready) begin
                sb_n.opc  = cmd_opcode;
                sb_n.data = alu_fn(cmd_opcode, cmd_op1, cmd_op2);
                sb_q.push_back(sb_n);
            end
        end
    end

    // Drives one command and returns #1 after the edge that accepted it.
    task automatic push_cmd(input logic [2:0] opc, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard;
        guard      = 0;
        cmd_valid  = 1'b1;
        cmd_opcode = opc;
        cmd_op1    = a;
        cmd_op2    = b;
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (!cmd_ready) check("push_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]   opc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   exp;
    } vec_t;

    vec_t vecs[6];

    int        t0;
    int        seen;
    int        times[$];
    logic [W:0] held;
    logic [2:0] fop [5];
    logic [W-1:0] fa [5];
    logic [W-1:0] fb [5];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{3'd0, 4'b0001, 4'b1000, 5'b01001};
        vecs[1] = '{3'd0, 4'b1111, 4'b0001, 5'b10000};
        vecs[2] = '{3'd1, 4'd5,    4'd3,    5'b00010};
        vecs[3] = '{3'd1, 4'd3,    4'd5,    5'b11110};
        vecs[4] = '{3'd2, 4'b1100, 4'b1010, 5'b01000};
        vecs[5] = '{3'd4, 4'b1100, 4'b1010, 5'b00110};

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_op1    = '0;
        cmd_op2    = '0;
        rsp_ready  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_opcode", 32'(OPCODE), 32'd0);
        check("rst_op1", 32'(OP1), 32'd0);
        check("rst_op2", 32'(OP2), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_opcode", 32'(rsp_opcode), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Table-driven single commands: issue timing, latency, result
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_cmd(vecs[i].opc, vecs[i].a, vecs[i].b);
            t0 = cyc;
            @(posedge clk);
            #1;
            check("issue_opcode", 32'(OPCODE), 32'(vecs[i].opc));
            check("issue_op1", 32'(OP1), 32'(vecs[i].a));
            check("issue_op2", 32'(OP2), 32'(vecs[i].b));
            while (!rsp_valid && (cyc - t0) < 20) begin
                @(posedge clk);
                #1;
            end
            check("rsp_latency", 32'(cyc - t0), 32'(2 + ALU_LAT));
            check("vec_rsp_data", 32'(rsp_data), 32'(vecs[i].exp));
            check("vec_rsp_opcode", 32'(rsp_opcode), 32'(vecs[i].opc));
            @(posedge clk);
            #1;
            check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        end

        // Fill with rsp_ready low: one in flight plus DEPTH queued closes the FIFO
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fop[i] = 3'(i);
            fa[i]  = 4'(3 * i + 1);
            fb[i]  = 4'(i + 7);
            push_cmd(fop[i], fa[i], fb[i]);
        end
        check("fill_ready_low", 32'(cmd_ready), 32'd0);
        check("fill_busy", 32'(busy), 32'd1);
        held = alu_fn(fop[0], fa[0], fb[0]);
        for (int k = 0; k < 4; k++) begin
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_data", 32'(rsp_data), 32'(held));
            check("hold_rsp_opcode", 32'(rsp_opcode), 32'(fop[0]));
            check("hold_op1", 32'(OP1), 32'(fa[0]));
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            @(posedge clk);
            #1;
        end

        // Drain back-to-back: responses exactly ALU_LAT+2 cycles apart
        rsp_ready = 1'b1;
        times.delete();
        for (int k = 0; k < 40 && times.size() < 5; k++) begin
            if (rsp_valid) times.push_back(cyc);
            @(posedge clk);
            #1;
        end
        check("drain_count", 32'(times.size()), 32'd5);
        for (int j = 1; j < times.size(); j++) begin
            check("b2b_spacing", 32'(times[j] - times[j-1]), 32'(ALU_LAT + 2));
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain_idle", 32'(busy), 32'd0);
        check("drain_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset while WAIT with two commands queued
        push_cmd(3'd0, 4'b0101, 4'b0011);
        push_cmd(3'd1, 4'b1001, 4'b0010);
        push_cmd(3'd3, 4'b0110, 4'b0001);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_op1", 32'(OP1), 32'(4'b0101));
        check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_op1", 32'(OP1), 32'd0);
        check("midrst_opcode", 32'(OPCODE), 32'd0);
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid || busy) seen++;
        end
        check("no_stale_rsp", 32'(seen), 32'd0);

`ifdef ALU_ISSUER_STATS_EN
        // Statistics: three issues, two stalled response cycles
        check("stats_issue_rst", 32'(issue_cnt), 32'd0);
        check("stats_stall_rst", 32'(stall_cnt), 32'd0);
        rsp_ready = 1'b0;
        push_cmd(3'd0, 4'd2, 4'd3);
        t0 = cyc;
        while (!rsp_valid && (cyc - t0) < 20) begin
            @(posedge clk);
            #1;
        end
        check("stats_first_rsp", 32'(rsp_valid), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        push_cmd(3'd2, 4'd7, 4'd5);
        push_cmd(3'd3, 4'd8, 4'd1);
        t0 = cyc;
        @(posedge clk);
        #1;
        while (busy && (cyc - t0) < 30) begin
            @(posedge clk);
            #1;
        end
        check("stats_idle", 32'(busy), 32'd0);
        check("stats_issue_cnt", 32'(issue_cnt), 32'd3);
        check("stats_stall_cnt", 32'(stall_cnt), 32'd2);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
